regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Owns the single write port of the 32x16 register file. After reset it sequences a full clear
//  (every register written with 0), then arbitrates two write-back requesters (ALU path = 0,
//  load/memory path = 1) onto the port using round-robin priority and valid/ready handshakes.
//  Sits between the write-back stage and the register file write inputs.
// PARAMETERS
//  DATA_W    16  width of register value
//  ADDR_W    5   register index width; clear sequence covers 2**ADDR_W entries
//  ZERO_REG  1   1: writes to register 0 are accepted but dropped (R0 reads 0); 0: normal
// PORTS
//  i_clk            in   1       clock, all state on rising edge
//  i_rst            in   1       asynchronous reset, active-high
//  i_wb0_valid      in   1       requester 0 (ALU) has a write pending
//  i_wb0_dest       in   ADDR_W  requester 0 destination register
//  i_wb0_val        in   DATA_W  requester 0 write data
//  o_wb0_ready      out  1       requester 0 granted this cycle (combinational)
//  i_wb1_valid      in   1       requester 1 (load) has a write pending
//  i_wb1_dest       in   ADDR_W  requester 1 destination register
//  i_wb1_val        in   DATA_W  requester 1 write data
//  o_wb1_ready      out  1       requester 1 granted this cycle (combinational)
//  o_write_enable   out  1       register-file write enable (registered)
//  o_dest           out  ADDR_W  register-file write index (registered)
//  o_input_val      out  DATA_W  register-file write data (registered)
//  o_clearing       out  1       high while clear sequence runs
// BEHAVIOUR
//  Reset (async, any time incl. mid-operation): state=CLEAR, clr_cnt=0, favour=0,
//   o_write_enable=0, o_dest=0, o_input_val=0; in-flight write dropped; clear restarts.
//  FSM CLEAR: o_clearing=1, both readys=0. Each rising edge registers we=1, dest=clr_cnt, val=0,
//   clr_cnt++. On the edge registering dest=2**ADDR_W-1, state->RUN. Clear = 2**ADDR_W cycles.
//  FSM RUN: o_clearing=0; never leaves RUN except via reset.
//  Grant (RUN only): only 0 valid -> ready0; only 1 valid -> ready1; both -> requester == favour.
//   Exactly zero or one ready high per cycle; ready never high without matching valid.
//  Transfer = valid & ready at a rising edge. Next cycle: o_write_enable=1, o_dest/o_input_val =
//   winner's dest/val. Latency 1 cycle, throughput 1 write/cycle, no bubbles.
//  favour toggles to the non-winner after every transfer; unchanged when no transfer.
//  Loser keeps valid high with stable dest/val until granted; worst-case wait 1 cycle.
//  ZERO_REG=1 and winner dest==0: transfer completes (ready high), o_write_enable=0 next cycle.
//  No transfer: o_write_enable=0 next cycle; o_dest/o_input_val hold last value.
//  Outputs change only on rising edge, stable for register file's falling-edge write.
//  Same dest from both requesters back-to-back: both written in grant order, last one wins.
// TESTING
//  T1 reset release, no requests -> 32 cycles we=1 dest=0..31 val=0, readys 0, then o_clearing=0.
//  T2 RUN, wb0 valid dest=5 val=0x1234 -> ready0 same cycle; next cycle we=1 dest=5 val=0x1234.
//  T3 both valid 4 cycles (favour=0) -> grants 0,1,0,1; writes appear 1 cycle later in that order.
//  T4 only wb1 valid 3 back-to-back (dest 7,8,9) -> 3 consecutive grants, writes 7,8,9, no gaps.
//  T5 ZERO_REG=1, wb0 dest=0 val=0xFFFF -> ready0=1, next cycle o_write_enable=0.
//  T6 i_rst pulsed mid-RUN with transfer in flight -> outputs 0 immediately, no write, T1 repeats.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the two write-back requesters and the register-file
// write arbiter, including the registered register-file write port.
//
// Handshake: a requester raises valid with stable dest/val and holds them until
// it sees ready in the same cycle; a transfer happens on the rising edge where
// valid and ready are both high. ready is never high without the matching valid.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  logic              i_wb0_valid;
  logic [ADDR_W-1:0] i_wb0_dest;
  logic [DATA_W-1:0] i_wb0_val;
  logic              o_wb0_ready;
  logic              i_wb1_valid;
  logic [ADDR_W-1:0] i_wb1_dest;
  logic [DATA_W-1:0] i_wb1_val;
  logic              o_wb1_ready;
  logic              o_write_enable;
  logic [ADDR_W-1:0] o_dest;
  logic [DATA_W-1:0] o_input_val;
  logic              o_clearing;
  logic              o_dbg_state;   // 0: CLEAR, 1: RUN

  // Arbiter side
  modport slave (
    input  i_wb0_valid, i_wb0_dest, i_wb0_val,
    input  i_wb1_valid, i_wb1_dest, i_wb1_val,
    output o_wb0_ready, o_wb1_ready,
    output o_write_enable, o_dest, o_input_val, o_clearing, o_dbg_state
  );

  // Requester / register-file side
  modport master (
    output i_wb0_valid, i_wb0_dest, i_wb0_val,
    output i_wb1_valid, i_wb1_dest, i_wb1_val,
    input  o_wb0_ready, o_wb1_ready,
    input  o_write_enable, o_dest, o_input_val, o_clearing, o_dbg_state
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Owner of the register-file write port. After reset it walks every register
// writing zero, then round-robins the ALU (0) and load (1) write-back paths
// onto the port with a one-cycle registered write.
module regfile_wb_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  regfile_wb_arbiter_if.slave   wb
);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              favour_q;
  logic              rdy0, rdy1, grant, drop;
  logic [ADDR_W-1:0] win_dest;
  logic [DATA_W-1:0] win_val;
  logic              we_q;
  logic [ADDR_W-1:0] dest_q;
  logic [DATA_W-1:0] val_q;

  // Next state and grant decision; favour only breaks ties
  always_comb begin
    state_d  = state_q;
    rdy0     = 1'b0;
    rdy1     = 1'b0;
    case (state_q)
      S_CLEAR: begin
        if (clr_cnt_q == {ADDR_W{1'b1}}) state_d = S_RUN;
      end
      S_RUN: begin
        if (wb.i_wb0_valid && wb.i_wb1_valid) begin
          rdy0 = !favour_q;
          rdy1 = favour_q;
        end else begin
          rdy0 = wb.i_wb0_valid;
          rdy1 = wb.i_wb1_valid;
        end
      end
      default: state_d = S_CLEAR;
    endcase
    grant    = rdy0 | rdy1;
    win_dest = rdy1 ? wb.i_wb1_dest : wb.i_wb0_dest;
    win_val  = rdy1 ? wb.i_wb1_val  : wb.i_wb0_val;
    // Writes to R0 complete the handshake but never reach the register file
    drop     = (ZERO_REG != 0) && (win_dest == '0);
  end

  // State register, clear counter, favour pointer and registered write port
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
      favour_q  <= 1'b0;
      we_q      <= 1'b0;
      dest_q    <= '0;
      val_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_CLEAR) begin
        we_q      <= 1'b1;
        dest_q    <= clr_cnt_q;
        val_q     <= '0;
        clr_cnt_q <= clr_cnt_q + 1'b1;
      end else if (grant) begin
        we_q     <= !drop;
        // A dropped R0 write leaves the port's index/data untouched
        if (!drop) begin
          dest_q <= win_dest;
          val_q  <= win_val;
        end
        // Hand priority to whoever did not win this transfer
        favour_q <= rdy0;
      end else begin
        we_q <= 1'b0;
      end
    end
  end

  assign wb.o_wb0_ready    = rdy0;
  assign wb.o_wb1_ready    = rdy1;
  assign wb.o_write_enable = we_q;
  assign wb.o_dest         = dest_q;
  assign wb.o_input_val    = val_q;
  assign wb.o_clearing     = (state_q == S_CLEAR);
  assign wb.o_dbg_state    = state_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: clear sequence, single/dual requester grants,
// R0 drop, idle hold and asynchronous reset mid-transfer.
module tb_regfile_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 16;
  localparam int W  = 1 + AW + DW;

  logic i_clk;
  logic i_rst;
  int   n_cmp;
  int   n_err;

  // Scoreboard of expected {we, dest, val} one cycle after each drive
  logic [W-1:0]  exp_q[$];
  logic          fav_m;
  logic [AW-1:0] last_dest;
  logic [DW-1:0] last_val;

  regfile_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) wb ();

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .wb    (wb)
  );

  // Clock and global time limit
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [W-1:0] out_word();
    return {wb.o_write_enable, wb.o_dest, wb.o_input_val};
  endfunction

  // Driver: called at a falling edge; applies inputs, samples readys, predicts
  // the next-cycle write and returns at the following falling edge.
  task automatic drive_cycle(input logic v0, input logic [AW-1:0] d0, input logic [DW-1:0] x0,
                             input logic v1, input logic [AW-1:0] d1, input logic [DW-1:0] x1,
                             output logic obs_r0, output logic obs_r1,
                             output logic exp_r0, output logic exp_r1);
    logic [AW-1:0] wd;
    logic [DW-1:0] wv;
    wb.i_wb0_valid = v0; wb.i_wb0_dest = d0; wb.i_wb0_val = x0;
    wb.i_wb1_valid = v1; wb.i_wb1_dest = d1; wb.i_wb1_val = x1;
    #1;
    obs_r0 = wb.o_wb0_ready;
    obs_r1 = wb.o_wb1_ready;
    exp_r0 = v0 && (!v1 || (fav_m == 1'b0));
    exp_r1 = v1 && (!v0 || (fav_m == 1'b1));
    if (exp_r0 || exp_r1) begin
      wd = exp_r0 ? d0 : d1;
      wv = exp_r0 ? x0 : x1;
      fav_m = exp_r0;
      if (wd == '0) exp_q.push_back({1'b0, last_dest, last_val});
      else begin
        exp_q.push_back({1'b1, wd, wv});
        last_dest = wd;
        last_val  = wv;
      end
    end else begin
      exp_q.push_back({1'b0, last_dest, last_val});
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic idle_inputs();
    wb.i_wb0_valid = 1'b0; wb.i_wb0_dest = '0; wb.i_wb0_val = '0;
    wb.i_wb1_valid = 1'b0; wb.i_wb1_dest = '0; wb.i_wb1_val = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    wb.i_wb0_valid = 1'b1;
    wb.i_wb0_dest  = 5'd3;
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    n_cmp++;
    if (out_word() !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 0", out_word());
    end
    n_cmp++;
    if ({wb.o_clearing, wb.o_wb0_ready, wb.o_wb1_ready, wb.o_dbg_state} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_status: got clr=%b r0=%b r1=%b st=%b expected 1 0 0 0",
               wb.o_clearing, wb.o_wb0_ready, wb.o_wb1_ready, wb.o_dbg_state);
    end
    i_rst = 1'b0;
  endtask

  // Clear walk after reset release; optionally with both requesters asking
  task automatic test_clear(input logic busy);
    idle_inputs();
    wb.i_wb0_valid = busy; wb.i_wb0_dest = 5'd9;  wb.i_wb0_val = 16'hAAAA;
    wb.i_wb1_valid = busy; wb.i_wb1_dest = 5'd10; wb.i_wb1_val = 16'h5555;
    for (int i = 0; i < 32; i++) begin
      #1;
      n_cmp++;
      if (wb.o_clearing !== 1'b1 || wb.o_wb0_ready !== 1'b0 || wb.o_wb1_ready !== 1'b0) begin
        n_err++;
        $display("FAIL clear_status[%0d]: got clr=%b r0=%b r1=%b expected 1 0 0",
                 i, wb.o_clearing, wb.o_wb0_ready, wb.o_wb1_ready);
      end
      @(posedge i_clk);
      @(negedge i_clk);
      n_cmp++;
      if (out_word() !== {1'b1, 5'(i), 16'h0000}) begin
        n_err++;
        $display("FAIL clear_write[%0d]: got %h expected %h", i, out_word(), {1'b1, 5'(i), 16'h0000});
      end
    end
    n_cmp++;
    if (wb.o_clearing !== 1'b0 || wb.o_dbg_state !== 1'b1) begin
      n_err++;
      $display("FAIL clear_done: got clr=%b st=%b expected 0 1", wb.o_clearing, wb.o_dbg_state);
    end
    idle_inputs();
    exp_q.delete();
    fav_m     = 1'b0;
    last_dest = 5'd31;
    last_val  = 16'h0000;
  endtask

  task automatic test_single_wb0();
    logic o0, o1, e0, e1;
    logic [W-1:0] exp;
    drive_cycle(1'b1, 5'd5, 16'h1234, 1'b0, 5'd0, 16'h0, o0, o1, e0, e1);
    n_cmp++;
    if ({o0, o1} !== 2'b10 || {e0, e1} !== 2'b10) begin
      n_err++;
      $display("FAIL wb0_ready: got %b%b expected 10", o0, o1);
    end
    idle_inputs();
    exp = exp_q.pop_front();
    n_cmp++;
    if (out_word() !== exp || exp !== {1'b1, 5'd5, 16'h1234}) begin
      n_err++;
      $display("FAIL wb0_write: got %h expected %h", out_word(), {1'b1, 5'd5, 16'h1234});
    end
  endtask

  task automatic test_back_to_back_wb1();
    logic o0, o1, e0, e1;
    logic [W-1:0] exp;
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1'b0, 5'd0, 16'h0, 1'b1, 5'(7 + k), 16'(16'h0700 + k), o0, o1, e0, e1);
      n_cmp++;
      if ({o0, o1} !== 2'b01 || {o0, o1} !== {e0, e1}) begin
        n_err++;
        $display("FAIL b2b_ready[%0d]: got %b%b expected 01", k, o0, o1);
      end
      exp = exp_q.pop_front();
      n_cmp++;
      if (out_word() !== exp) begin
        n_err++;
        $display("FAIL b2b_write[%0d]: got %h expected %h", k, out_word(), exp);
      end
    end
    idle_inputs();
  endtask

  task automatic test_round_robin();
    logic o0, o1, e0, e1;
    logic [W-1:0] exp;
    logic [3:0] pat;
    int k0, k1;
    pat = 4'b1010;   // grant to requester 0 on cycles 0 and 2
    k0 = 0; k1 = 0;
    for (int c = 0; c < 4; c++) begin
      drive_cycle(1'b1, 5'(10 + k0), 16'(16'h0A00 + k0),
                  1'b1, 5'(20 + k1), 16'(16'h0B00 + k1), o0, o1, e0, e1);
      n_cmp++;
      if (o0 !== pat[3 - c] || o1 !== !pat[3 - c] || o0 !== e0) begin
        n_err++;
        $display("FAIL rr_grant[%0d]: got r0=%b r1=%b expected r0=%b r1=%b", c, o0, o1, pat[3 - c], !pat[3 - c]);
      end
      if (o0) k0++;
      if (o1) k1++;
      exp = exp_q.pop_front();
      n_cmp++;
      if (out_word() !== exp) begin
        n_err++;
        $display("FAIL rr_write[%0d]: got %h expected %h", c, out_word(), exp);
      end
    end
    idle_inputs();
  endtask

  task automatic test_same_dest();
    logic o0, o1, e0, e1;
    logic [W-1:0] exp;
    logic [DW-1:0] v0;
    logic g0_done;
    g0_done = 1'b0;
    for (int c = 0; c < 2; c++) begin
      v0 = 16'h1111;
      drive_cycle(!g0_done, 5'd15, v0, 1'b1, 5'd15, 16'h2222, o0, o1, e0, e1);
      if (o0) g0_done = 1'b1;
      exp = exp_q.pop_front();
      n_cmp++;
      if (out_word() !== exp) begin
        n_err++;
        $display("FAIL same_dest[%0d]: got %h expected %h", c, out_word(), exp);
      end
    end
    n_cmp++;
    if (out_word() !== {1'b1, 5'd15, 16'h2222}) begin
      n_err++;
      $display("FAIL same_dest_last: got %h expected %h", out_word(), {1'b1, 5'd15, 16'h2222});
    end
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    logic o0, o1, e0, e1;
    logic [W-1:0] exp;
    drive_cycle(1'b1, 5'd0, 16'hFFFF, 1'b0, 5'd0, 16'h0, o0, o1, e0, e1);
    n_cmp++;
    if (o0 !== 1'b1 || o1 !== 1'b0) begin
      n_err++;
      $display("FAIL zero_ready: got r0=%b r1=%b expected 1 0", o0, o1);
    end
    idle_inputs();
    exp = exp_q.pop_front();
    n_cmp++;
    if (wb.o_write_enable !== 1'b0 || out_word() !== exp) begin
      n_err++;
      $display("FAIL zero_write: got %h expected %h", out_word(), exp);
    end
  endtask

  task automatic test_idle_hold();
    logic o0, o1, e0, e1;
    logic [W-1:0] exp;
    for (int c = 0; c < 2; c++) begin
      drive_cycle(1'b0, 5'($urandom_range(0, 31)), 16'($urandom_range(0, 65535)),
                  1'b0, 5'($urandom_range(0, 31)), 16'($urandom_range(0, 65535)), o0, o1, e0, e1);
      exp = exp_q.pop_front();
      n_cmp++;
      if ({o0, o1} !== 2'b00 || out_word() !== exp) begin
        n_err++;
        $display("FAIL idle_hold[%0d]: got r=%b%b out=%h expected r=00 out=%h", c, o0, o1, out_word(), exp);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic o0, o1, e0, e1;
    logic [W-1:0] exp;
    drive_cycle(1'b1, 5'd3, 16'hABCD, 1'b0, 5'd0, 16'h0, o0, o1, e0, e1);
    exp = exp_q.pop_front();
    n_cmp++;
    if (out_word() !== exp) begin
      n_err++;
      $display("FAIL pre_reset_write: got %h expected %h", out_word(), exp);
    end
    wb.i_wb0_valid = 1'b1; wb.i_wb0_dest = 5'd4; wb.i_wb0_val = 16'hBEEF;
    #1;
    i_rst = 1'b1;
    #1;
    n_cmp++;
    if (out_word() !== '0 || wb.o_wb0_ready !== 1'b0 || wb.o_clearing !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset: got out=%h r0=%b clr=%b expected 0 0 1", out_word(), wb.o_wb0_ready, wb.o_clearing);
    end
    @(posedge i_clk);
    @(negedge i_clk);
    n_cmp++;
    if (out_word() !== '0) begin
      n_err++;
      $display("FAIL reset_no_write: got %h expected 0", out_word());
    end
    i_rst = 1'b0;
    test_clear(1'b1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    fav_m = 1'b0;
    last_dest = '0;
    last_val  = '0;
    i_rst = 1'b1;
    idle_inputs();
    @(negedge i_clk);
    test_reset();
    test_clear(1'b0);
    test_single_wb0();
    test_back_to_back_wb1();
    test_round_robin();
    test_same_dest();
    test_zero_reg();
    test_idle_hold();
    test_reset_mid_run();
    test_single_wb0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
